// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the push-button conditioner.
//   - btn_state_e : per-channel press / auto-repeat state.
//   - cnt_width() : counter width for a terminal count; never narrower than 1.
//   - max_u()     : larger of two unsigned values, for sizing shared counters.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // debounced level low
        ST_HELD = 2'd1,  // level high, no auto-repeat
        ST_WAIT = 2'd2,  // level high, counting towards the first repeat
        ST_RPT  = 2'd3   // level high, emitting periodic repeats
    } btn_state_e;

    // Width of a counter that has to reach n-1. A width of 0 is not legal,
    // so tiny counts still get a single bit.
    function automatic int cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One push-button channel: 2-FF synchroniser, counter-based debounce,
//   one-cycle press/release pulses and optional auto-repeat.
//
// Ports
//   clk         in  system clock, all logic on the rising edge
//   rst_n       in  synchronous reset, active HIGH despite the name
//   btn_in      in  raw asynchronous button, 1 = pressed
//   rpt_en      in  auto-repeat enable, synchronous to clk
//   btn_level   out debounced button level (flop)
//   btn_press   out 1-cycle pulse on debounced rise or repeat tick (flop)
//   btn_release out 1-cycle pulse on debounced fall (flop)
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    parameter int unsigned RPT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic rpt_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int RPT_W = cnt_width(max_u(RPT_DELAY, RPT_PERIOD));

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            rise, fall;

    // The counter only advances while the synchronised input disagrees with
    // the current level; any agreement restarts qualification from zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = sync2_q;
            db_cnt_d = '0;
            rise     = sync2_q;
            fall     = ~sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: rst_n is active high here and sampled only on the clock edge;
        // there is no asynchronous reset path in this block.
        if (rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync2_q take the old
            // sync1_q, giving a true two-stage synchroniser.
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Press / release / auto-repeat FSM
    // rise/fall fire in the same cycle that level_q updates, so the pulses
    // line up with the level change.
    // ------------------------------------------------------------------
    btn_state_e       state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // Pulses are single-cycle: cleared unless re-asserted below.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        press_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                        state_q   <= rpt_en ? ST_WAIT : ST_HELD;
                    end
                end
                ST_HELD: begin
                    // rpt_en is ignored here until the next press.
                    if (fall) begin
                        release_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A fall beats timer expiry; dropping rpt_en beats it too.
                    if (fall) begin
                        release_q <= 1'b1;
                        rpt_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (!rpt_en) begin
                        rpt_cnt_q <= '0;
                        state_q   <= ST_HELD;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        press_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                        state_q   <= ST_RPT;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                ST_RPT: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        rpt_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (!rpt_en) begin
                        rpt_cnt_q <= '0;
                        state_q   <= ST_HELD;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        press_q   <= 1'b1;
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    rpt_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule : debounce_channel

// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
//   N_CH independent push-button conditioners, one debounce_channel each.
//   Channels share only clock and reset, so simultaneous events on different
//   channels all pulse in the same cycle.
//
// Ports
//   clk         in  system clock, rising edge
//   rst_n       in  synchronous reset, active HIGH (name kept for the design)
//   btn_in      in  [N_CH] raw asynchronous buttons, 1 = pressed
//   rpt_en      in  [N_CH] per-channel auto-repeat enable
//   btn_level   out [N_CH] debounced levels
//   btn_press   out [N_CH] 1-cycle press / repeat pulses
//   btn_release out [N_CH] 1-cycle release pulses
// -----------------------------------------------------------------------------
module debouncer_bank #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    parameter int unsigned RPT_PERIOD = 10_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] rpt_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_in      (btn_in[g]),
            .rpt_en      (rpt_en[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g])
        );
    end

endmodule : debouncer_bank
